// File: rtl/acorn128_aead_if.sv
// Request/response bundle between the ACORN top level and its datapath core.
// The master drives the job; the slave (core) returns results.
interface acorn128_aead_if #(
    parameter int AD_BITS  = 128,
    parameter int MSG_BITS = 128
);
    logic                start_in;
    logic                decrypt_in;
    logic [127:0]        key_in;
    logic [127:0]        iv_in;
    logic [AD_BITS-1:0]  ad_in;
    logic [MSG_BITS-1:0] data_in;
    logic [127:0]        tag_in;
    logic                busy_out;
    logic                done_out;
    logic [MSG_BITS-1:0] data_out;
    logic [127:0]        tag_out;
    logic                tag_ok_out;

    modport master (
        output start_in, decrypt_in, key_in, iv_in, ad_in, data_in, tag_in,
        input  busy_out, done_out, data_out, tag_out, tag_ok_out
    );

    modport slave (
        input  start_in, decrypt_in, key_in, iv_in, ad_in, data_in, tag_in,
        output busy_out, done_out, data_out, tag_out, tag_ok_out
    );
endinterface

// File: rtl/acorn128_aead_core.sv
// ACORN-128 v3 single-block AEAD datapath: STEP_W state-update steps per
// clock on one 293-bit state, sequenced INIT -> AD -> MSG -> FIN.
module acorn128_aead_core #(
    parameter int STEP_W   = 8,
    parameter int AD_BITS  = 128,
    parameter int MSG_BITS = 128
) (
    input logic            clk,
    input logic            rst_n,
    acorn128_aead_if.slave bus
);
    localparam int AD_P  = AD_BITS + 256;
    localparam int MSG_P = MSG_BITS + 256;
    localparam int BIG   = (AD_P > MSG_P) ? AD_P : MSG_P;
    localparam int MAXP  = (BIG > 1792) ? BIG : 1792;
    localparam int PW    = $clog2(MAXP + 1);
    localparam int CW    = $clog2(MAXP / STEP_W);

    localparam logic [CW-1:0] INIT_LAST = CW'(1792 / STEP_W - 1);
    localparam logic [CW-1:0] AD_LAST   = CW'(AD_P / STEP_W - 1);
    localparam logic [CW-1:0] MSG_LAST  = CW'(MSG_P / STEP_W - 1);
    localparam logic [CW-1:0] FIN_LAST  = CW'(768 / STEP_W - 1);
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [PW-1:0] P_STEP    = PW'(STEP_W);
    localparam logic [PW-1:0] P128      = PW'(128);
    localparam logic [PW-1:0] P256      = PW'(256);
    localparam logic [PW-1:0] P640      = PW'(640);
    localparam logic [PW-1:0] AD_END    = PW'(AD_BITS);
    localparam logic [PW-1:0] AD_CA     = PW'(AD_BITS + 128);
    localparam logic [PW-1:0] MSG_END   = PW'(MSG_BITS);
    localparam logic [PW-1:0] MSG_CA    = PW'(MSG_BITS + 128);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_AD, S_MSG, S_FIN} state_e;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // Six LFSR taps, updated in order so each uses the older neighbour.
    function automatic logic [292:0] lfsr_upd(input logic [292:0] s);
        logic [292:0] t;
        t      = s;
        t[289] = t[289] ^ t[235] ^ t[230];
        t[230] = t[230] ^ t[196] ^ t[193];
        t[193] = t[193] ^ t[160] ^ t[154];
        t[154] = t[154] ^ t[111] ^ t[107];
        t[107] = t[107] ^ t[66] ^ t[61];
        t[61]  = t[61] ^ t[23] ^ t[0];
        return t;
    endfunction

    state_e               st_q, st_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic [292:0]         s_q, s_d;
    logic [127:0]         key_q, key_d;
    logic [127:0]         iv_q, iv_d;
    logic [AD_BITS-1:0]   ad_q, ad_d;
    logic [MSG_BITS-1:0]  msg_q, msg_d;
    logic [127:0]         tin_q, tin_d;
    logic [127:0]         tg_q, tg_d;
    logic                 dec_q, dec_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [MSG_BITS-1:0]  dout_q, dout_d;
    logic [127:0]         tout_q, tout_d;
    logic                 ok_q, ok_d;

    logic [292:0]         s_w, t_w;
    logic [STEP_W-1:0]    ks_v, out_v;
    logic                 ks_w, mk_w, ob_w, ca_w, cb_w;
    logic                 key_rgn, ad_live, msg_live;

    assign key_rgn  = (pos_q < P128) || (pos_q >= P256);
    assign ad_live  = pos_q < AD_END;
    assign msg_live = pos_q < MSG_END;

    always_comb begin
        ca_w = 1'b1;
        cb_w = 1'b1;
        unique case (1'b1)
            st_q == S_AD:  ca_w = pos_q < AD_CA;
            st_q == S_MSG: begin
                ca_w = pos_q < MSG_CA;
                cb_w = 1'b0;
            end
            default: ;
        endcase
    end

    // Unrolled STEP_W steps; step k sees the state left by step k-1.
    always_comb begin
        s_w   = s_q;
        t_w   = s_q;
        ks_v  = '0;
        out_v = '0;
        ks_w  = 1'b0;
        mk_w  = 1'b0;
        ob_w  = 1'b0;
        for (int k = 0; k < STEP_W; k++) begin
            t_w  = lfsr_upd(s_w);
            ks_w = t_w[12] ^ t_w[154] ^ maj(t_w[235], t_w[61], t_w[193])
                 ^ ch(t_w[230], t_w[111], t_w[66]);
            ob_w = 1'b0;
            mk_w = 1'b0;
            case (st_q)
                S_INIT: mk_w = (key_rgn ? key_q[k] : iv_q[k])
                             ^ ((k == 0) && (pos_q == P256));
                S_AD: mk_w = ad_live ? ad_q[k]
                                     : ((k == 0) && (pos_q == AD_END));
                S_MSG: begin
                    if (msg_live) begin
                        ob_w = msg_q[k] ^ ks_w;
                        mk_w = dec_q ? ob_w : msg_q[k];
                    end else begin
                        mk_w = (k == 0) && (pos_q == MSG_END);
                    end
                end
                default: mk_w = 1'b0;
            endcase
            ks_v[k]  = ks_w;
            out_v[k] = ob_w;
            s_w = {t_w[0] ^ ~t_w[107] ^ maj(t_w[244], t_w[23], t_w[160])
                   ^ (ca_w & t_w[196]) ^ (cb_w & ks_w) ^ mk_w, t_w[292:1]};
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        s_d    = s_q;
        key_d  = key_q;
        iv_d   = iv_q;
        ad_d   = ad_q;
        msg_d  = msg_q;
        tin_d  = tin_q;
        tg_d   = tg_q;
        dec_d  = dec_q;
        busy_d = busy_q;
        done_d = 1'b0;
        dout_d = dout_q;
        tout_d = tout_q;
        ok_d   = ok_q;
        if (st_q == S_IDLE) begin
            if (bus.start_in) begin
                st_d   = S_INIT;
                cnt_d  = INIT_LAST;
                pos_d  = '0;
                s_d    = '0;
                key_d  = bus.key_in;
                iv_d   = bus.iv_in;
                ad_d   = bus.ad_in;
                msg_d  = bus.data_in;
                tin_d  = bus.tag_in;
                tg_d   = '0;
                dec_d  = bus.decrypt_in;
                busy_d = 1'b1;
            end
        end else begin
            s_d   = s_w;
            pos_d = pos_q + P_STEP;
            cnt_d = cnt_q - C_ONE;
            // Consumed input bits shift out; MSG output bits refill from the top.
            unique case (st_q)
                S_INIT: begin
                    if (key_rgn) key_d = {key_q[STEP_W-1:0], key_q[127:STEP_W]};
                    else         iv_d  = iv_q >> STEP_W;
                end
                S_AD:  if (ad_live) ad_d = ad_q >> STEP_W;
                S_MSG: if (msg_live) msg_d = MSG_BITS'({out_v, msg_q} >> STEP_W);
                default: if (pos_q >= P640) tg_d = 128'({ks_v, tg_q} >> STEP_W);
            endcase
            if (cnt_q == '0) begin
                pos_d = '0;
                unique case (st_q)
                    S_INIT: begin st_d = S_AD;  cnt_d = AD_LAST;  end
                    S_AD:   begin st_d = S_MSG; cnt_d = MSG_LAST; end
                    S_MSG:  begin st_d = S_FIN; cnt_d = FIN_LAST; end
                    default: begin
                        st_d   = S_IDLE;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        dout_d = msg_q;
                        tout_d = tg_d;
                        ok_d   = dec_q & (tg_d == tin_q);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= S_IDLE;
            cnt_q  <= '0;
            pos_q  <= '0;
            s_q    <= '0;
            key_q  <= '0;
            iv_q   <= '0;
            ad_q   <= '0;
            msg_q  <= '0;
            tin_q  <= '0;
            tg_q   <= '0;
            dec_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dout_q <= '0;
            tout_q <= '0;
            ok_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            s_q    <= s_d;
            key_q  <= key_d;
            iv_q   <= iv_d;
            ad_q   <= ad_d;
            msg_q  <= msg_d;
            tin_q  <= tin_d;
            tg_q   <= tg_d;
            dec_q  <= dec_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dout_q <= dout_d;
            tout_q <= tout_d;
            ok_q   <= ok_d;
        end
    end

    assign bus.busy_out   = busy_q;
    assign bus.done_out   = done_q;
    assign bus.data_out   = dout_q;
    assign bus.tag_out    = tout_q;
    assign bus.tag_ok_out = ok_q;
endmodule

// File: doc/acorn128_aead_core.md
Name: acorn128_aead_core

Overview:
- Parametrised ACORN-128 (v3) authenticated-cipher engine: one 128-bit message block, one associated-data field, encrypt and decrypt modes, tag generation and tag check.
- Processes STEP_W state-update steps per clock.
- Owns a single 293-bit state register and sequences init, AD, message and finalization from one counter-driven FSM.
- Sits under the ACORN top level as its datapath.

Parameters:
- STEP_W, 8: state-update steps per clock. Legal values are 1, 2, 4, 8, 16, 32. Must divide AD_BITS, MSG_BITS, 256 and 768.
- AD_BITS, 128: associated-data length in bits. Multiple of STEP_W, ≥ STEP_W.
- MSG_BITS, 128: message length in bits. Multiple of STEP_W, ≥ STEP_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start_in  in  1  start request; sampled only in IDLE
- decrypt_in  in  1  0 = encrypt, 1 = decrypt; captured with start
- key_in  in  128  key
- iv_in  in  128  nonce
- ad_in  in  AD_BITS  associated data
- data_in  in  MSG_BITS  plaintext (encrypt) or ciphertext (decrypt)
- tag_in  in  128  expected tag (decrypt only)
- busy_out  out  1  high while stepping
- done_out  out  1  one-cycle completion pulse
- data_out  out  MSG_BITS  ciphertext (encrypt) or plaintext (decrypt)
- tag_out  out  128  computed tag
- tag_ok_out  out  1  decrypt: tag_out equals tag_in; encrypt: 0

Behaviour:
- Reset: rst_n sampled low at a clk edge forces the following on the next edge:
  - FSM to IDLE, state register to 0, counter to 0;
  - busy_out = 0, done_out = 0, data_out = 0, tag_out = 0, tag_ok_out = 0.
  - This applies mid-operation too; the in-flight job is abandoned and no done pulse is produced.
- Bit order: bit 0 of every input vector is consumed first. Within one clock, step k uses the state produced by step k-1.
- Step (per bit, ACORN-128 v3):
  - ks = S12 ^ S154 ^ maj(S235,S61,S193) ^ ch(S230,S111,S66).
  - f = S0 ^ ~S107 ^ maj(S244,S23,S160) ^ (ca & S196) ^ (cb & ks).
  - The LFSR feedback pre-update is applied first, then shift, then S292 = f ^ m.
- Phases, with step index i counted within the phase:
  - INIT, 1792 steps, ca = cb = 1. m is key bit i for i < 128, iv bit i-128 for i < 256, key[0]^1 at i = 256, then key bit (i mod 128).
  - AD, AD_BITS+256 steps. m = ad bit, then 1, then 0s. ca = 1 while i < AD_BITS+128; cb = 1 while i < AD_BITS+256.
  - MSG, MSG_BITS+256 steps. For i < MSG_BITS:
    - encrypt: m = data_in bit, out bit = m ^ ks;
    - decrypt: out bit = data_in bit ^ ks, m = out bit.
    - After the message bits, padding is 1 then 0s. ca = 1 while i < MSG_BITS+128; cb = 0.
  - FIN, 768 steps, m = 0, ca = cb = 1. tag_out = ks of the last 128 steps, earliest step in bit 0.
- FSM: IDLE → INIT → AD → MSG → FIN → IDLE.
  - Phase counter counts clocks; it reloads to (phase_steps/STEP_W)-1 on entry and advances the phase at 0.
  - Counter width covers 1792/STEP_W.
- Handshake:
  - In IDLE, start_in = 1 registers key, iv, ad, data, tag_in and mode, and zeroes the state.
  - busy_out rises the next cycle.
  - start_in while busy_out = 1 is ignored and has no effect on the running job.
- Latency:
  - N = (1792 + AD_BITS + 256 + MSG_BITS + 256 + 768)/STEP_W stepping cycles. Default N = 416.
  - start sampled at edge 0 → busy_out = 1 for edges 1..N.
  - done_out = 1 for exactly the cycle after edge N; busy_out = 0 in that cycle.
  - data_out, tag_out and tag_ok_out update together with done_out and hold until the next accepted start or reset.
- Back-to-back: start_in may be high in the done_out cycle. It is accepted, since the FSM is already in IDLE.

Test Plan:
- Encrypt key = 0, iv = 0, ad = 0, pt = 0, defaults → done_out exactly 417 cycles after the start edge, busy_out high 416 cycles. data_out and tag_out match the ACORN-128 C golden model.
- Encrypt with key = 000102…0F, iv = 0F0E…00, ad = 1122…FF, pt = DEADBEEF repeated. Feed resulting ciphertext and tag into decrypt → data_out = original pt, tag_ok_out = 1, tag_out identical.
- Same decrypt with tag_in bit 0 flipped, or one ciphertext bit flipped → tag_ok_out = 0; the ciphertext-flip case also changes tag_out.
- Pulse start_in at cycles 5 and 200 of a running job → single done_out, at cycle 417 after the first start; outputs equal to an undisturbed run.
- Assert rst_n low at cycle 100 of a job → all outputs 0 the next cycle, no done_out. A fresh start then gives the same result as a clean run.
- Regress STEP_W = 1, 8, 32 (N = 3328, 416, 104) with identical vectors → bit-identical data_out and tag_out. Also back-to-back start issued in the done_out cycle is accepted.
